// File: rtl/pc_branch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_branch_ctrl_if
//  Description : Bundle of control, LUT-write and status signals between the
//                program-counter / branch-control stage and its environment.
//                master : environment side (drives controls, reads status)
//                slave  : pc_branch_ctrl side
//  Signals     : Start/StartAddr, BranchEn/BranchAbs/LutIdx/Offset,
//                AluOut/Zero, HaltInstr, LutWe/LutWaddr/LutWdata (inputs to
//                the stage); ProgCtr, Running, Taken, Done (stage outputs).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_branch_ctrl_if #(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 16
);
    localparam int c_lut_aw = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;

    logic                start;
    logic                Start;
    logic [PC_W-1:0]     StartAddr;
    logic                BranchEn;
    logic                BranchAbs;
    logic [c_lut_aw-1:0] LutIdx;
    logic [7:0]          Offset;
    logic [7:0]          AluOut;
    logic                Zero;
    logic                HaltInstr;
    logic                LutWe;
    logic [c_lut_aw-1:0] LutWaddr;
    logic [PC_W-1:0]     LutWdata;
    logic [PC_W-1:0]     ProgCtr;
    logic                Running;
    logic                Taken;
    logic                Done;

    modport master (
        output Start, StartAddr, BranchEn, BranchAbs, LutIdx, Offset,
               AluOut, Zero, HaltInstr, LutWe, LutWaddr, LutWdata,
        input  ProgCtr, Running, Taken, Done
    );

    modport slave (
        input  Start, StartAddr, BranchEn, BranchAbs, LutIdx, Offset,
               AluOut, Zero, HaltInstr, LutWe, LutWaddr, LutWdata,
        output ProgCtr, Running, Taken, Done
    );
endinterface
`default_nettype wire

// File: rtl/pc_branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_branch_ctrl
//  Description : Program-counter and branch-control stage of the 8-bit
//                processor. Every cycle in RUN it advances the PC by one,
//                takes a relative or LUT-based absolute branch, or halts.
//                A small writable LUT holds absolute branch targets.
//  Ports       : Clk   - clock, rising edge
//                Reset - synchronous active-high reset
//                bus   - pc_branch_ctrl_if.slave (controls in, PC/status out)
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_branch_ctrl #(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 16
) (
    input  wire logic       Clk,
    input  wire logic       Reset,
    pc_branch_ctrl_if.slave bus
);

    localparam int c_lut_aw = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic            r_taken;
    logic            w_taken_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            r_running;
    logic            w_running_nxt;

    logic [PC_W-1:0] r_lut [LUT_DEPTH];
    logic [PC_W-1:0] w_lut_rd;
    logic [PC_W-1:0] w_offset_sext;
    logic            w_branch_taken;

    // ------------------------------------------------------------------------
    // Sign-extend the 8-bit offset to the PC width. Adding it modulo 2^PC_W
    // gives the wrap-around behaviour for branches below zero for free.
    // ------------------------------------------------------------------------
    generate
        if (PC_W > 8) begin : g_sext_wide
            assign w_offset_sext = {{(PC_W-8){bus.Offset[7]}}, bus.Offset};
        end else begin : g_sext_narrow
            assign w_offset_sext = bus.Offset[PC_W-1:0];
        end
    endgenerate

    // The LUT is read from the registered array, so a write in the same cycle
    // is not yet visible: the branch sees the old entry.
    assign w_lut_rd       = r_lut[bus.LutIdx];
    // The comparison result is carried on Zero; a non-zero ALU result takes
    // the branch.
    assign w_branch_taken = bus.BranchEn & ~bus.Zero;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_taken_nxt = 1'b0;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (bus.Start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = bus.StartAddr;
                end
            end
            ST_RUN: begin
                if (bus.HaltInstr) begin
                    // Halt wins over any branch in the same instruction.
                    w_state_nxt = ST_HALTED;
                    w_done_nxt  = 1'b1;
                end else if (w_branch_taken) begin
                    w_taken_nxt = 1'b1;
                    if (bus.BranchAbs) begin
                        w_pc_nxt = w_lut_rd;
                    end else begin
                        w_pc_nxt = r_pc + w_offset_sext;
                    end
                end else begin
                    w_pc_nxt = r_pc + PC_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_running_nxt = (w_state_nxt == ST_RUN);
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_taken   <= 1'b0;
            r_done    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_taken   <= w_taken_nxt;
            r_done    <= w_done_nxt;
            r_running <= w_running_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Branch-target LUT: writable in any state, cleared by reset
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                r_lut[i] <= '0;
            end
        end else if (bus.LutWe) begin
            r_lut[bus.LutWaddr] <= bus.LutWdata;
        end
    end

    assign bus.ProgCtr = r_pc;
    assign bus.Running = r_running;
    assign bus.Taken   = r_taken;
    assign bus.Done    = r_done;

endmodule
`default_nettype wire

// File: doc/pc_branch_ctrl.md
# pc_branch_ctrl

Program-counter and branch-control stage for the 8-bit processor, sitting directly downstream of the ALU. Each cycle it consumes the ALU result (`AluOut`, `Zero`) with decoded branch/halt controls and produces the next instruction address. It holds a small writable branch-target lookup table and runs a start/run/halt handshake with the top-level testbench.

## Interface
- `PC_W`, default 10: program counter width; the address space is 2^PC_W.
- `LUT_DEPTH`, default 16: number of absolute branch-target entries; the index width is log2(LUT_DEPTH).
- `Clk`  in  1: clock; everything updates on the rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `Start`  in  1: begins execution at `StartAddr`; honoured only in IDLE or HALTED.
- `StartAddr`  in  PC_W: first instruction address.
- `BranchEn`  in  1: the current instruction is a conditional branch.
- `BranchAbs`  in  1: 1 takes the target from LUT[`LutIdx`]; 0 is relative by `Offset`.
- `LutIdx`  in  log2(LUT_DEPTH): LUT read index.
- `Offset`  in  8: signed two's-complement relative offset.
- `AluOut`  in  8: ALU result; GEQ/EQ/NEQ produce 0 or 1.
- `Zero`  in  1: ALU zero flag (`AluOut` == 0).
- `HaltInstr`  in  1: the current instruction is halt.
- `LutWe`  in  1: LUT write enable.
- `LutWaddr`  in  log2(LUT_DEPTH): LUT write index.
- `LutWdata`  in  PC_W: LUT write data.
- `ProgCtr`  out  PC_W: current instruction address; registered.
- `Running`  out  1: high while in RUN.
- `Taken`  out  1: registered; high for the cycle after a taken branch.
- `Done`  out  1: one-cycle pulse on entry to HALTED.

## Operation
- FSM states: IDLE, RUN, HALTED.
- **IDLE**
  - `ProgCtr` holds.
  - `Start` loads `ProgCtr` <= `StartAddr` and moves to RUN.
- **RUN**, priority order, evaluated each cycle:
  1. `HaltInstr`: go to HALTED, `ProgCtr` holds, `Done` <= 1. Halt beats a simultaneous branch.
  2. Taken = `BranchEn` && !`Zero`.
     - Absolute: `ProgCtr` <= LUT[`LutIdx`].
     - Relative: `ProgCtr` <= (`ProgCtr` + sign-extended `Offset`) mod 2^PC_W.
     - `Taken` <= 1.
  3. Otherwise: `ProgCtr` <= (`ProgCtr` + 1) mod 2^PC_W, `Taken` <= 0.
- `Start` is ignored in RUN.
- **HALTED**
  - `ProgCtr` holds; `Done` falls after one cycle.
  - `Start` restarts exactly as from IDLE.
- Wrap-around:
  - `ProgCtr` = 2^PC_W−1 incrementing goes to 0.
  - A relative branch below 0 wraps modulo 2^PC_W.
- `Offset` = 0 with a taken branch gives a legal self-loop: `ProgCtr` is unchanged and `Taken` = 1.
- LUT writes:
  - Accepted in any state.
  - A same-cycle write and read of one index returns the old value; the new value is visible from the next cycle.
- `BranchEn`, `HaltInstr` and `BranchAbs` are ignored outside RUN.

## Timing
- Reset values:
  - `ProgCtr` = 0, state IDLE, `Running` = 0, `Taken` = 0, `Done` = 0.
  - All LUT entries = 0.
- Reset has priority over `Start`, `LutWe` and all RUN activity, including mid-program.
- One-cycle latency: inputs sampled at edge N appear on `ProgCtr`, `Taken` and `Done` after edge N.
- `Running` rises the cycle after `Start` is sampled and falls the cycle after `HaltInstr` is sampled (the same edge `Done` rises).
- `Start` held high across HALTED gives one restart, then is ignored in RUN.
- There are no combinational paths from inputs to outputs.

## Test plan
1. **Sequential fetch:** `Reset`, then `Start` with `StartAddr`=5, no branches for 3 cycles -> `ProgCtr` goes 5, 6, 7, 8; `Running`=1; `Taken`=0.
2. **Relative branches:** in RUN at `ProgCtr`=20, `BranchEn`=1, `BranchAbs`=0, `Offset`=−4 (0xFC), `Zero`=0 -> next `ProgCtr`=16, `Taken`=1. Same stimulus with `Zero`=1 -> `ProgCtr`=21, `Taken`=0.
3. **Absolute branch:** write LUT[3]=0x2A0, then branch with `BranchAbs`=1, `LutIdx`=3, `Zero`=0 -> `ProgCtr`=0x2A0. A same-cycle write and read of LUT[3] with new data 0x001 -> the branch still goes to 0x2A0.
4. **Wrap:** `StartAddr`=1023, one increment -> `ProgCtr`=0. At `ProgCtr`=2, relative `Offset`=−3 taken -> `ProgCtr`=1023.
5. **Halt:** `HaltInstr`=1 together with a taken branch at `ProgCtr`=40 -> `ProgCtr` stays 40, `Done` pulses exactly one cycle, `Running`=0. Then `Start` with `StartAddr`=0 -> RUN from 0.
6. **Reset mid-run:** assert `Reset` at `ProgCtr`=77 while `Start`=1 and `LutWe`=1 -> next cycle `ProgCtr`=0, IDLE, all outputs 0, LUT[any]=0.
